sram256x8_arbiter: RTL and testbench

- Shares one 256x8 single-port synchronous SRAM macro between two requesters: port 0 is the CPU load/store unit and port 1 is the tile/video fetch unit.
- Optionally clears the whole array after reset, before any requester is served.
- Drives the macro's active-low controls (CEN, GWEN, per-bit WEN) and returns read data one cycle after grant.
- Sits directly in front of the SRAM wrapper instance.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/sram256x8_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram256x8_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 256x8 SRAM arbiter: widths, the controller
// state encoding and the request bundle steered onto the macro pins.
package sram_ctrl_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEPTH  = 2 ** DEF_AW;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
    logic [DEF_DW-1:0] wmask;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins at once, and on contention
// the port that was not granted most recently wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic [1:0] gnt_s;
  logic       ptr_r;

  // ptr_r = 1 means port 1 wins the next tie
  always_comb begin
    gnt_s = 2'b00;
    case (req)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11:   gnt_s = ptr_r ? 2'b10 : 2'b01;
      default: gnt_s = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (gnt_s[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt_s[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;
  assign ptr = ptr_r;

endmodule

// File: rtl/sram256x8_arbiter.sv
// Front end for a 256x8 single-port SRAM shared by the CPU (port 0) and the
// tile fetch unit (port 1), with an optional post-reset clear sweep.
module sram256x8_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter int            DW         = DEF_DW,
  parameter bit            INIT_CLEAR = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m0_wmask,
  output logic          m0_gnt,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [DW-1:0] m1_wmask,
  output logic          m1_gnt,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          sram_cen_n,
  output logic          sram_gwen_n,
  output logic [DW-1:0] sram_wen_n,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic          init_done_r;
  logic          rsp_valid_r;
  logic          rsp_id_r;

  logic [1:0]    arb_req_s;
  logic [1:0]    gnt_s;
  logic          arb_ptr_s;
  logic          sel1_s;
  logic          rd_gnt_s;
  req_t          sel_s;

  // Requests stay pending (ungranted) while the clear sweep owns the macro
  assign arb_req_s = (state_r == RUN) ? {m1_req, m0_req} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req_s),
    .gnt   (gnt_s),
    .ptr   (arb_ptr_s)
  );

  // Data steering straight from requests and pointer, so it does not wait on gnt
  assign sel1_s   = m1_req & (~m0_req | arb_ptr_s);
  assign rd_gnt_s = (|gnt_s) & ~sel_s.we;

  // Pick the request bundle that would win this cycle
  always_comb begin
    sel_s = '0;
    if (sel1_s) begin
      sel_s.we    = m1_we;
      sel_s.addr  = m1_addr;
      sel_s.wdata = m1_wdata;
      sel_s.wmask = m1_wmask;
    end else begin
      sel_s.we    = m0_we;
      sel_s.addr  = m0_addr;
      sel_s.wdata = m0_wdata;
      sel_s.wmask = m0_wmask;
    end
  end

  // SRAM pin drive: clear-sweep write, granted access, or idle
  always_comb begin
    sram_cen_n  = 1'b1;
    sram_gwen_n = 1'b1;
    sram_wen_n  = {DW{1'b1}};
    sram_a      = {AW{1'b0}};
    sram_d      = {DW{1'b0}};
    case (state_r)
      INIT: begin
        sram_cen_n  = 1'b0;
        sram_gwen_n = 1'b0;
        sram_wen_n  = {DW{1'b0}};
        sram_a      = cnt_r;
        sram_d      = INIT_VALUE;
      end
      RUN: begin
        if (|gnt_s) begin
          sram_cen_n  = 1'b0;
          sram_gwen_n = ~sel_s.we;
          sram_wen_n  = sel_s.we ? ~sel_s.wmask : {DW{1'b1}};
          sram_a      = sel_s.addr;
          sram_d      = sel_s.wdata;
        end else begin
          sram_cen_n  = 1'b1;
        end
      end
      default: begin
        sram_cen_n  = 1'b1;
      end
    endcase
  end

  // Controller FSM: clear sweep, then service loop with the read response stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT_CLEAR ? INIT : RUN;
      cnt_r       <= {AW{1'b0}};
      init_done_r <= ~INIT_CLEAR;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          cnt_r       <= cnt_r + 1'b1;
          rsp_valid_r <= 1'b0;
          if (&cnt_r) begin
            state_r     <= RUN;
            init_done_r <= 1'b1;
          end else begin
            state_r     <= INIT;
            init_done_r <= 1'b0;
          end
        end
        RUN: begin
          rsp_valid_r <= rd_gnt_s;
          if (rd_gnt_s) begin
            rsp_id_r <= gnt_s[1];
          end else begin
            rsp_id_r <= rsp_id_r;
          end
        end
        default: begin
          state_r     <= INIT;
          cnt_r       <= {AW{1'b0}};
          init_done_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_rdata = sram_q;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_sram256x8_arbiter.sv
// Directed bench for sram256x8_arbiter with a behavioural 256x8 SRAM macro.
module tb_sram256x8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m0_wmask, m1_addr, m1_wdata, m1_wmask;
  logic       m0_gnt, m1_gnt, rsp_valid, rsp_id, init_done;
  logic [7:0] rsp_rdata;
  logic       sram_cen_n, sram_gwen_n;
  logic [7:0] sram_wen_n, sram_a, sram_d;
  logic [7:0] sram_q = 8'h00;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sram256x8_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(m1_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_cen_n(sram_cen_n), .sram_gwen_n(sram_gwen_n), .sram_wen_n(sram_wen_n),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural macro, preloaded with junk so the clear sweep is visible
  initial for (int k = 0; k < 256; k++) mem[k] = 8'h5A;

  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (!sram_gwen_n) mem[sram_a] <= (mem[sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
      else              sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_wmask = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_wmask = 8'h00;
    repeat (3) tick;
    chk("reset_state", {m0_gnt, m1_gnt, init_done, rsp_valid, rsp_id},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Clear sweep with port 0 read of 0x10 pending from cycle 0
    rst_n = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
    #1;
    for (int i = 0; i < 256; i++) begin
      chk("init_sweep", {m0_gnt, init_done, sram_cen_n, sram_gwen_n, sram_wen_n, sram_a, sram_d},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'(i), 8'h00});
      tick;
    end
    chk("init_done_grant", {init_done, m0_gnt, sram_cen_n, sram_gwen_n, sram_a},
        {1'b1, 1'b1, 1'b0, 1'b1, 8'h10});

    tick;
    chk("cleared_read_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    m0_we = 1'b1; m0_wdata = 8'hA5; m0_wmask = 8'hFF;
    #1;
    chk("write_a5_drive", {m0_gnt, sram_gwen_n, sram_wen_n, sram_a, sram_d},
        {1'b1, 1'b0, 8'h00, 8'h10, 8'hA5});

    tick;
    chk("write_no_rsp", {31'd0, rsp_valid}, 32'd0);
    m0_we = 1'b0;
    #1;
    chk("read_a5_grant", {m0_gnt, sram_gwen_n, sram_wen_n}, {1'b1, 1'b1, 8'hFF});

    tick;
    chk("read_a5_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 1'b0, 8'hA5});
    m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 8'hFF; m0_wmask = 8'h0F;
    #1;
    chk("masked_write_wen", {m0_gnt, sram_gwen_n, sram_wen_n}, {1'b1, 1'b0, 8'hF0});

    tick;
    m0_we = 1'b0;
    #1;
    chk("masked_read_grant", {30'd0, m0_gnt, sram_gwen_n}, {30'd0, 1'b1, 1'b1});

    tick;
    chk("masked_read_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 1'b0, 8'h0F});
    m0_req = 1'b0;
    #1;
    chk("idle_pins", {m0_gnt, m1_gnt, sram_cen_n, sram_gwen_n, sram_wen_n, sram_a, sram_d},
        {1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00});

    // Port 1 alone: four back-to-back reads of cleared words
    for (int i = 0; i < 4; i++) begin
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'(i);
      #1;
      chk("p1_grant", {m1_gnt, m0_gnt, sram_a}, {1'b1, 1'b0, 8'(i)});
      tick;
      chk("p1_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 1'b1, 8'h00});
    end

    // Contention: grants must alternate starting with port 0
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_grant", {m1_gnt, m0_gnt}, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick;
      chk("rr_rsp", {rsp_valid, rsp_id, rsp_rdata},
          (i % 2 == 1) ? {1'b1, 1'b1, 8'h0F} : {1'b1, 1'b0, 8'hA5});
    end
    m1_req = 1'b0;

    // Reset lands just before the edge that would register a read response
    m0_addr = 8'h10;
    #1;
    chk("pre_reset_grant", {31'd0, m0_gnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    tick;
    chk("reset_drop", {rsp_valid, init_done, m0_gnt, sram_a}, {1'b0, 1'b0, 1'b0, 8'h00});
    tick;
    rst_n = 1'b1;
    #1;
    chk("reinit_addr0", {m0_gnt, init_done, sram_gwen_n, sram_a}, {1'b0, 1'b0, 1'b0, 8'h00});
    tick;
    chk("reinit_addr1", {m0_gnt, init_done, rsp_valid, sram_a}, {1'b0, 1'b0, 1'b0, 8'h01});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
